relu6_ram_ctrl: RTL and testbench

RELU6_RAM_CTRL -- requirements
Module: relu6_ram_ctrl

---
 rtl/relu6_ram_ctrl.sv | 123 ++++++++++++
 tb/tb_relu6_ram_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/relu6_ram_ctrl.sv
// relu6_ram_ctrl: fill/drain sequencer for the layer-6 feature-vector RAM.
// Optional sticky protocol-error flag enabled by defining RELU6_CTRL_ERR_EN.
module relu6_ram_ctrl #(
    parameter int DEPTH = 16,
    parameter int AW    = 7,
    parameter int PW    = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          start,
    input  logic [PW-1:0] passes,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr,
    output logic          out_valid,
    output logic          out_last,
    output logic          buf_full,
    output logic          err
);

    localparam logic [1:0] S_FILL  = 2'd0;
    localparam logic [1:0] S_FULL  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_FLUSH = 2'd3;

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
    localparam logic [PW-1:0] ONE  = PW'(1);

    logic [1:0]    state;
    logic [AW-1:0] wcnt;
    logic [AW-1:0] rcnt;
    logic [PW-1:0] pcnt;
    logic          rd_final;

    // Strobes are gated by rst so nothing reaches the RAM in a reset cycle.
    assign in_ready = rst && (state == S_FILL);
    assign wr_en    = in_ready && in_valid;
    assign wr_addr  = rst ? wcnt : '0;
    assign rd_en    = rst && (state == S_DRAIN);
    assign rd_addr  = rst ? rcnt : '0;
    assign buf_full = rst && (state == S_FULL);
    assign rd_final = rd_en && (rcnt == LAST) && (pcnt == ONE);

    // Main sequencer: write counter, read/pass counters and state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_FILL;
            wcnt  <= '0;
            rcnt  <= '0;
            pcnt  <= '0;
        end else begin
            unique case (state)
                S_FILL: begin
                    if (in_valid) begin
                        if (wcnt == LAST) begin
                            wcnt  <= '0;
                            state <= S_FULL;
                        end else begin
                            wcnt <= wcnt + 1'b1;
                        end
                    end
                end
                S_FULL: begin
                    if (start) begin
                        pcnt  <= (passes == '0) ? ONE : passes;
                        state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (rcnt == LAST) begin
                        rcnt <= '0;
                        if (pcnt == ONE) begin
                            state <= S_FLUSH;
                        end else begin
                            pcnt <= pcnt - ONE;
                        end
                    end else begin
                        rcnt <= rcnt + 1'b1;
                    end
                end
                S_FLUSH: begin
                    state <= S_FILL;
                end
                default: begin
                    state <= S_FILL;
                end
            endcase
        end
    end

    // RAM read data appears one cycle after the read strobe.
    always_ff @(posedge clk) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            out_valid <= rd_en;
            out_last  <= rd_final;
        end
    end

`ifdef RELU6_CTRL_ERR_EN
    logic err_q;

    // Sticky flag: producer pushed outside FILL or consumer started outside FULL.
    always_ff @(posedge clk) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else if ((in_valid && state != S_FILL) ||
                     (start && state != S_FULL)) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_relu6_ram_ctrl.sv
// tb_relu6_ram_ctrl: phase table, directed corner sequences and random
// stimulus against a queue-based reference model of the controller.
module tb_relu6_ram_ctrl;

    localparam int DEPTH = 16;
    localparam int AW    = 7;
    localparam int PW    = 8;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic          start;
    logic [PW-1:0] passes;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic          out_valid;
    logic          out_last;
    logic          buf_full;
    logic          err;

    relu6_ram_ctrl #(
        .DEPTH(DEPTH),
        .AW   (AW),
        .PW   (PW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .start    (start),
        .passes   (passes),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .out_valid(out_valid),
        .out_last (out_last),
        .buf_full (buf_full),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Reference model: number of vectors written, queue of pending read
    // addresses for the whole drain, and a one-cycle flush marker.
    int  m_nwr   = 0;
    int  m_q[$];
    bit  m_flush = 0;
    bit  m_ov    = 0;
    bit  m_ol    = 0;
    bit  m_err   = 0;
    bit  armed   = 0;

    // Last sampled DUT outputs for phase counting and directed checks.
    bit s_wr, s_rd, s_ov, s_ol, s_rdy, s_full;
    int s_wa, s_ra;

    typedef struct {
        string       name;
        bit          rst_n;
        bit          iv;
        bit          st;
        int unsigned pas;
        bit          gap;
        int          n;
        int          wr;
        int          rd;
        int          ov;
        int          lst;
        bit          full_after;
        bit          rdy_after;
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got %0d want %0d",
                     name, cyc, act, exp);
        end
    endtask

    task automatic cycle();
        bit reading, filling, fullst;
        bit e_rdy, e_wr, e_rd, e_full;
        int e_wa, e_ra;
        @(negedge clk);
        reading = (m_q.size() != 0);
        filling = !reading && !m_flush && (m_nwr < DEPTH);
        fullst  = !reading && !m_flush && (m_nwr == DEPTH);
        e_rdy  = rst && filling;
        e_wr   = e_rdy && in_valid;
        e_wa   = (rst && filling) ? m_nwr : 0;
        e_rd   = rst && reading;
        e_ra   = (rst && reading) ? m_q[0] : 0;
        e_full = rst && fullst;
        if (armed) begin
            chk("in_ready", int'(in_ready), int'(e_rdy));
            chk("wr_en", int'(wr_en), int'(e_wr));
            chk("rd_en", int'(rd_en), int'(e_rd));
            chk("buf_full", int'(buf_full), int'(e_full));
            chk("out_valid", int'(out_valid), int'(m_ov));
            chk("out_last", int'(out_last), int'(m_ol));
            chk("err", int'(err), int'(m_err));
            if (e_wr || !rst) chk("wr_addr", int'(wr_addr), e_wa);
            if (e_rd || !rst) chk("rd_addr", int'(rd_addr), e_ra);
        end
        s_wr   = armed && wr_en;
        s_rd   = armed && rd_en;
        s_ov   = armed && out_valid;
        s_ol   = armed && out_last;
        s_rdy  = in_ready;
        s_full = buf_full;
        s_wa   = int'(wr_addr);
        s_ra   = int'(rd_addr);
        @(posedge clk);
        if (!rst) begin
            armed   = 1;
            m_nwr   = 0;
            m_q.delete();
            m_flush = 0;
            m_ov    = 0;
            m_ol    = 0;
            m_err   = 0;
        end else begin
`ifdef RELU6_CTRL_ERR_EN
            if ((in_valid && !filling) || (start && !fullst)) m_err = 1;
`endif
            m_ov = reading;
            m_ol = reading && (m_q.size() == 1);
            if (reading) begin
                void'(m_q.pop_front());
                if (m_q.size() == 0) m_flush = 1;
            end else if (m_flush) begin
                m_flush = 0;
            end else if (fullst) begin
                if (start) begin
                    for (int p = 0; p < ((passes == 0) ? 1 : int'(passes)); p++)
                        for (int a = 0; a < DEPTH; a++) m_q.push_back(a);
                    m_nwr = 0;
                end
            end else if (in_valid) begin
                m_nwr++;
            end
        end
        cyc++;
        #1;
    endtask

    task automatic drive(input bit r, input bit iv, input bit st,
                         input int unsigned p);
        rst      = r;
        in_valid = iv;
        start    = st;
        passes   = PW'(p);
    endtask

    task automatic run_phase(input vec_t v);
        int wr = 0, rd = 0, ov = 0, lst = 0;
        for (int k = 0; k < v.n; k++) begin
            drive(v.rst_n, v.iv && (!v.gap || (k % 3) == 0), v.st, v.pas);
            cycle();
            wr += int'(s_wr);
            rd += int'(s_rd);
            ov += int'(s_ov);
            lst += int'(s_ol);
        end
        drive(1, 0, 0, 0);
        #1;
        chk({v.name, "/writes"}, wr, v.wr);
        chk({v.name, "/reads"}, rd, v.rd);
        chk({v.name, "/out_valid"}, ov, v.ov);
        chk({v.name, "/out_last"}, lst, v.lst);
        chk({v.name, "/buf_full"}, int'(buf_full), int'(v.full_after));
        chk({v.name, "/in_ready"}, int'(in_ready), int'(v.rdy_after));
    endtask

    initial begin
        drive(0, 0, 0, 0);

        tbl[0]  = '{"reset",         0, 0, 0, 0, 0,  2,  0,  0,  0, 0, 0, 1};
        tbl[1]  = '{"fill16",        1, 1, 0, 0, 0, 16, 16,  0,  0, 0, 1, 0};
        tbl[2]  = '{"iv_in_full",    1, 1, 0, 0, 0,  3,  0,  0,  0, 0, 1, 0};
        tbl[3]  = '{"start_p3",      1, 0, 1, 3, 0,  1,  0,  0,  0, 0, 0, 0};
        tbl[4]  = '{"drain_p3_iv",   1, 1, 0, 0, 0, 48,  0, 48, 47, 0, 0, 0};
        tbl[5]  = '{"flush_p3",      1, 0, 0, 0, 0,  1,  0,  0,  1, 1, 0, 1};
        tbl[6]  = '{"start_in_fill", 1, 0, 1, 2, 0,  2,  0,  0,  0, 0, 0, 1};
        tbl[7]  = '{"gapped_fill",   1, 1, 0, 0, 1, 46, 16,  0,  0, 0, 1, 0};
        tbl[8]  = '{"start_p0",      1, 0, 1, 0, 0,  1,  0,  0,  0, 0, 0, 0};
        tbl[9]  = '{"drain_p0",      1, 0, 0, 0, 0, 16,  0, 16, 15, 0, 0, 0};
        tbl[10] = '{"flush_p0",      1, 0, 0, 0, 0,  1,  0,  0,  1, 1, 0, 1};

        for (int i = 0; i < 11; i++) run_phase(tbl[i]);

        // Start arriving with the final write of a fill is dropped.
        for (int k = 0; k < 15; k++) begin
            drive(1, 1, 0, 0);
            cycle();
        end
        drive(1, 1, 1, 2);
        cycle();
        chk("final_write_addr", s_wa, DEPTH - 1);
        for (int k = 0; k < 3; k++) begin
            drive(1, 0, 0, 0);
            cycle();
            chk("late_start_no_read", int'(s_rd), 0);
            chk("late_start_full", int'(s_full), 1);
        end
        drive(1, 0, 1, 1);
        cycle();
        for (int k = 0; k < DEPTH + 1; k++) begin
            drive(1, 0, 0, 0);
            cycle();
        end

        // Reset lands on read 7 of the second pass.
        for (int k = 0; k < DEPTH; k++) begin
            drive(1, 1, 0, 0);
            cycle();
        end
        drive(1, 0, 1, 3);
        cycle();
        for (int k = 0; k < DEPTH + 7; k++) begin
            drive(1, 0, 0, 0);
            cycle();
        end
        chk("pre_reset_last_rd", s_ra, 6);
        drive(0, 0, 0, 0);
        cycle();
        chk("reset_rd_en", int'(s_rd), 0);
        chk("reset_in_ready", int'(s_rdy), 0);
        drive(1, 1, 0, 0);
        cycle();
        chk("post_reset_rd_en", int'(s_rd), 0);
        chk("post_reset_out_valid", int'(s_ov), 0);
        chk("post_reset_in_ready", int'(s_rdy), 1);
        chk("post_reset_wr_addr", s_wa, 0);

        // Random traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            drive(($urandom_range(0, 199) != 0),
                  $urandom_range(0, 1) == 1,
                  $urandom_range(0, 7) == 0,
                  $urandom_range(0, 3));
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
